// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: rebuilds four scanned 7-segment glyphs into frame codes.
// Filters ghosting with a settle counter, flags bad anode patterns and stale scans.
// Optional: define SCAN_ORDER_CHECK_EN to enforce capture order 0->1->2->3->0.
module seven_seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        origin_clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [19:0] frame_code,
  output logic [3:0]  frame_dp,
  output logic        frame_valid,
  output logic        an_err,
  output logic        stale,
  output logic        order_err
);

  localparam int unsigned SMP_W  = 12;
  localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] SETTLE_V  = STAB_W'(SETTLE_CYCLES);
  localparam logic [STAB_W-1:0] SETTLE_M1 = STAB_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

  logic [SMP_W-1:0]  smp_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [3:0]        mask_q, mask_d;
  logic [19:0]       shadow_q, shadow_d;
  logic [3:0]        dp_sh_q, dp_sh_d;
  logic [19:0]       frame_code_q, frame_code_d;
  logic [3:0]        frame_dp_q, frame_dp_d;
  logic              frame_valid_q, frame_valid_d;
  logic              an_err_q, an_err_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic              stale_q, stale_d;

  logic [SMP_W-1:0]  in_c;
  logic              settle_c;
  logic              one_low_c;
  logic              blank_c;
  logic [1:0]        idx_c;
  logic              capture_c;
  logic [4:0]        code_c;
  logic [3:0]        onehot_c;
  logic [3:0]        mask_new_c;

`ifdef SCAN_ORDER_CHECK_EN
  logic [1:0]        last_q, last_d;
  logic              order_err_q, order_err_d;
`endif

  // Map the active-low segment pattern (dp excluded) to a 5-bit glyph code.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] c;
    case (g)
      7'b1000000: c = 5'h00;
      7'b1111001: c = 5'h01;
      7'b0100100: c = 5'h02;
      7'b0110000: c = 5'h03;
      7'b0011001: c = 5'h04;
      7'b0010010: c = 5'h05;
      7'b0000010: c = 5'h06;
      7'b1111000: c = 5'h07;
      7'b0000000: c = 5'h08;
      7'b0010000: c = 5'h09;
      7'b0001000: c = 5'h0A;
      7'b0000011: c = 5'h0B;
      7'b1000110: c = 5'h0C;
      7'b0100001: c = 5'h0D;
      7'b0000110: c = 5'h0E;
      7'b0001110: c = 5'h0F;
      7'b1011100: c = 5'h10;
      7'b1100011: c = 5'h11;
      default:    c = 5'h1F;
    endcase
    return c;
  endfunction

  assign in_c = {an, seg};

  // Settle counter: one event when the sample has been identical SETTLE_CYCLES times.
  always_comb begin
    stab_d   = stab_q;
    settle_c = 1'b0;
    if (in_c != smp_q) begin
      stab_d = '0;
    end else if (stab_q != SETTLE_V) begin
      stab_d   = stab_q + STAB_W'(1);
      settle_c = (stab_q == SETTLE_M1);
    end
  end

  // Classify the anode pattern: single digit select, blank, or fault.
  always_comb begin
    one_low_c = 1'b1;
    idx_c     = 2'd0;
    blank_c   = (an == 4'b1111);
    case (an)
      4'b1110: idx_c = 2'd0;
      4'b1101: idx_c = 2'd1;
      4'b1011: idx_c = 2'd2;
      4'b0111: idx_c = 2'd3;
      default: one_low_c = 1'b0;
    endcase
  end

  assign capture_c = settle_c & one_low_c;
  assign code_c    = decode_glyph(seg[6:0]);
  assign onehot_c  = 4'(1) << idx_c;

  // Capture into the shadow, track the mask and publish complete frames.
  always_comb begin
    mask_d        = mask_q;
    shadow_d      = shadow_q;
    dp_sh_d       = dp_sh_q;
    frame_code_d  = frame_code_q;
    frame_dp_d    = frame_dp_q;
    frame_valid_d = 1'b0;
    an_err_d      = settle_c & ~one_low_c & ~blank_c;
    mask_new_c    = mask_q | onehot_c;
`ifdef SCAN_ORDER_CHECK_EN
    last_d        = last_q;
    order_err_d   = 1'b0;
`endif
    if (capture_c) begin
      for (int j = 0; j < 4; j++) begin
        if (idx_c == 2'(j)) begin
          shadow_d[5*j +: 5] = code_c;
          dp_sh_d[j]         = ~seg[7];
        end
      end
`ifdef SCAN_ORDER_CHECK_EN
      if ((idx_c != last_q) && (idx_c != (last_q + 2'd1))) begin
        order_err_d = 1'b1;
        mask_new_c  = onehot_c;
      end
      last_d = idx_c;
`endif
      if (mask_new_c == 4'b1111) begin
        frame_code_d  = shadow_d;
        frame_dp_d    = dp_sh_d;
        frame_valid_d = 1'b1;
        mask_d        = 4'b0000;
      end else begin
        mask_d = mask_new_c;
      end
    end
  end

  // Staleness timer: cleared by any capture, saturates at the timeout.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (capture_c) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TIMEOUT_V) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end
    stale_d = (to_cnt_d == TIMEOUT_V);
  end

  // State registers.
  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q         <= '0;
      stab_q        <= '0;
      mask_q        <= '0;
      shadow_q      <= '0;
      dp_sh_q       <= '0;
      frame_code_q  <= 20'hFFFFF;
      frame_dp_q    <= '0;
      frame_valid_q <= 1'b0;
      an_err_q      <= 1'b0;
      to_cnt_q      <= '0;
      stale_q       <= 1'b0;
    end else begin
      smp_q         <= in_c;
      stab_q        <= stab_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      dp_sh_q       <= dp_sh_d;
      frame_code_q  <= frame_code_d;
      frame_dp_q    <= frame_dp_d;
      frame_valid_q <= frame_valid_d;
      an_err_q      <= an_err_d;
      to_cnt_q      <= to_cnt_d;
      stale_q       <= stale_d;
    end
  end

`ifdef SCAN_ORDER_CHECK_EN
  // Order tracker; reset so that digit 0 is the expected first capture.
  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 2'd3;
      order_err_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

  assign frame_code  = frame_code_q;
  assign frame_dp    = frame_dp_q;
  assign frame_valid = frame_valid_q;
  assign an_err      = an_err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench for seven_seg_scan_decoder (SETTLE_CYCLES=4, TIMEOUT_CYCLES=100).
module tb_seven_seg_scan_decoder;

  typedef struct packed {
    logic [19:0] code;
    logic [3:0]  dp;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [7:0]  seg = 8'hFF;
  logic [19:0] frame_code;
  logic [3:0]  frame_dp;
  logic        frame_valid;
  logic        an_err;
  logic        stale;
  logic        order_err;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     an_err_seen = 0;
  int     order_err_seen = 0;
  int     an_err_exp = 0;
  int     order_err_exp = 0;

  seven_seg_scan_decoder #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (16)
  ) dut (
    .origin_clk (clk),
    .rst_n      (rst_n),
    .an         (an),
    .seg        (seg),
    .frame_code (frame_code),
    .frame_dp   (frame_dp),
    .frame_valid(frame_valid),
    .an_err     (an_err),
    .stale      (stale),
    .order_err  (order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input int i, input logic [7:0] s);
    logic [3:0] a;
    a = ~(4'(1) << i);
    drive(a, s, 10);
  endtask

  task automatic expect_frame(input logic [19:0] c, input logic [3:0] d);
    frame_t f;
    f.code = c;
    f.dp   = d;
    exp_q.push_back(f);
  endtask

  // Monitor: pops the scoreboard on each frame_valid and counts error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(frame_code), 32'hFFFFFFFF);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          check("frame_code", 32'(frame_code), 32'(f.code));
          check("frame_dp", 32'(frame_dp), 32'(f.dp));
        end
      end
      if (an_err) an_err_seen++;
      if (order_err) order_err_seen++;
    end
  end

  initial begin
    // Asynchronous reset without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_code", 32'(frame_code), 32'hFFFFF);
    check("rst_dp", 32'(frame_dp), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    check("rst_an_err", 32'(an_err), 32'h0);
    check("rst_order_err", 32'(order_err), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, 8'hFF, 5);

    // Nominal frame: up, down, '2', '1'; latency check on digit 3.
    expect_frame({5'h01, 5'h02, 5'h11, 5'h10}, 4'b0000);
    dig(0, 8'b11011100);
    dig(1, 8'b11100011);
    dig(2, 8'b10100100);
    drive(4'b0111, 8'b11111001, 4);
    check("latency_before", 32'(frame_valid), 32'h0);
    drive(4'b0111, 8'b11111001, 1);
    check("latency_at", 32'(frame_valid), 32'h1);
    drive(4'b0111, 8'b11111001, 5);

    // Ghost filter: 3-cycle all-lit glitch ahead of every digit, dp on digits 1 and 3.
    expect_frame({5'h0F, 5'h0A, 5'h07, 5'h00}, 4'b1010);
    drive(4'b1110, 8'h00, 3); dig(0, 8'b11000000);
    drive(4'b1101, 8'h00, 3); dig(1, 8'b01111000);
    drive(4'b1011, 8'h00, 3); dig(2, 8'b10001000);
    drive(4'b0111, 8'h00, 3); dig(3, 8'b00001110);

    // Anode fault and blank mid-frame leave the partial frame intact.
    expect_frame({5'h0B, 5'h0C, 5'h1F, 5'h0E}, 4'b0000);
    dig(0, 8'b10000110);
    dig(1, 8'hFF);
    an_err_exp++;
    drive(4'b1100, 8'b10000110, 6);
    drive(4'b1111, 8'b10000110, 10);
    dig(2, 8'b11000110);
    dig(3, 8'b10000011);

    // Re-capture of digit 0 overwrites the earlier glyph.
    expect_frame({5'h04, 5'h03, 5'h09, 5'h06}, 4'b0000);
    dig(0, 8'b10010010);
    dig(0, 8'b10000010);
    dig(1, 8'b10010000);
    dig(2, 8'b10110000);
    dig(3, 8'b10011001);

    // Stale: 100 cycles after the last capture, cleared by the next capture.
    expect_frame({5'h04, 5'h03, 5'h02, 5'h01}, 4'b0000);
    drive(4'b1110, 8'b11111001, 5);
    drive(4'hF, 8'hFF, 99);
    check("stale_pre", 32'(stale), 32'h0);
    drive(4'hF, 8'hFF, 1);
    check("stale_set", 32'(stale), 32'h1);
    drive(4'b1101, 8'b10100100, 4);
    check("stale_hold", 32'(stale), 32'h1);
    drive(4'b1101, 8'b10100100, 1);
    check("stale_clear", 32'(stale), 32'h0);
    drive(4'b1101, 8'b10100100, 5);
    dig(2, 8'b10110000);
    dig(3, 8'b10011001);

    // Reset mid-frame discards the partial mask and shadow.
    dig(0, 8'b11111001);
    dig(1, 8'b10100100);
    dig(2, 8'b10110000);
    drive(4'hF, 8'hFF, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_code", 32'(frame_code), 32'hFFFFF);
    check("midrst_dp", 32'(frame_dp), 32'h0);
    check("midrst_stale", 32'(stale), 32'h0);
    check("midrst_valid", 32'(frame_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, 8'hFF, 5);
    expect_frame({5'h0D, 5'h0B, 5'h00, 5'h09}, 4'b0000);
    dig(3, 8'b10100001);
    dig(0, 8'b10010000);
    dig(1, 8'b11000000);
    dig(2, 8'b10000011);

    // Capture order 3,0,2 skips digit 1; frame completes after 3,0,1.
    expect_frame({5'h0A, 5'h07, 5'h0E, 5'h0C}, 4'b0000);
`ifdef SCAN_ORDER_CHECK_EN
    order_err_exp++;
`endif
    dig(3, 8'b10000000);
    dig(0, 8'b10010010);
    dig(2, 8'b11111000);
    dig(3, 8'b10001000);
    dig(0, 8'b11000110);
    dig(1, 8'b10000110);

    drive(4'hF, 8'hFF, 10);
    check("frames_pending", 32'(exp_q.size()), 32'h0);
    check("an_err_count", 32'(an_err_seen), 32'(an_err_exp));
    check("order_err_count", 32'(order_err_seen), 32'(order_err_exp));
    check("stale_end", 32'(stale), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment display interface: monitors the scanned an/seg lines driven by the display scanner and rebuilds the four displayed glyphs as codes.
- Used as a board-level self-check and as the bench-side checker for display logic.
- Filters scan-transition ghosting, validates the anode pattern and assembles complete 4-digit frames.
- A staleness flag reports when the scan has stopped.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical {an,seg} samples required before a digit is captured (>=1).
- TIMEOUT_CYCLES, 40000, origin_clk cycles without any capture before stale asserts.
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- origin_clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- an  in  4  anode lines, active-low, an[i] selects digit i.
- seg  in  8  segment lines, active-low, seg[6:0]=ca..cg, seg[7]=dp.
- frame_code  out  20  four 5-bit codes, digit i at [5i+4:5i].
- frame_dp  out  4  dp lit (1) per digit, same frame.
- frame_valid  out  1  one-cycle pulse when frame_code/frame_dp update.
- an_err  out  1  one-cycle pulse on a settled an pattern with more than one low bit.
- stale  out  1  level; no capture for TIMEOUT_CYCLES.
- order_err  out  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset values (async, on rst_n low):
  - frame_code = 20'hFFFFF (all codes 5'h1F), frame_dp = 0.
  - frame_valid = an_err = order_err = stale = 0.
  - Internal mask, shadow, sample and counters cleared.
- Sampling:
  - smp <= {an,seg} every edge.
  - stab_cnt clears to 0 when {an,seg} != smp; otherwise it increments, saturating at SETTLE_CYCLES.
  - The settle event fires on the edge where stab_cnt becomes SETTLE_CYCLES. There is exactly one event per stable window.
- Settle event classification on an:
  - Exactly one bit low: capture digit i.
  - 4'b1111: blank; no capture, no error.
  - Any other pattern: an_err pulses next cycle; no capture; mask unchanged.
- Glyph decode of seg[6:0], dp ignored, to a 5-bit code:
  - Hex 0-F: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
  - Up glyph 1011100 -> 5'h10; down glyph 1100011 -> 5'h11.
  - Anything else -> 5'h1F.
  - dp_lit = ~seg[7].
- Capture:
  - shadow[i] <= code; dp_sh[i] <= dp_lit; mask[i] <= 1.
  - Re-capturing a digit already in mask overwrites its shadow entry; mask is unchanged.
- Frame assembly:
  - When mask|onehot(i) == 4'b1111 at a capture, the same edge loads frame_code/frame_dp from shadow with the new digit merged.
  - frame_valid is asserted for that one cycle and mask clears to 0.
  - Latency from the last input change of digit 3 to frame_valid = SETTLE_CYCLES+1 edges.
- Timeout:
  - to_cnt clears on every capture and otherwise increments, saturating.
  - stale asserts when to_cnt reaches TIMEOUT_CYCLES and deasserts on the edge of the next capture.
  - On a capture coinciding with the timeout boundary, the capture wins and stale stays 0.
- Reset mid-frame discards the partial mask and shadow; the frame outputs return to reset values.

Optional Feature:
- Macro: SCAN_ORDER_CHECK_EN.
- Defined:
  - Tracks the last captured digit index and expects captures in order 0->1->2->3->0.
  - An out-of-order capture still writes shadow[i], pulses order_err next cycle, and resets mask to onehot(i). The frame restarts from that digit.
  - Re-capture of the same index is not an error.
- Undefined: no order tracking; order_err is tied 0; any capture order completes a frame.

Test Plan:
- Reset check: assert rst_n=0 mid-run -> frame_code=20'hFFFFF, frame_dp=0, stale=0, mask cleared, with no clock edge required.
- Nominal frame, SETTLE_CYCLES=4:
  - Stimulus: scan an=1110/1101/1011/0111 with seg up-glyph 11011100, down 11100011, 10100100 ('2'), 11111001 ('1'), each held 10 cycles.
  - Required: one frame_valid with frame_code = {5'h01,5'h02,5'h11,5'h10}, frame_dp=0.
- Ghost filter: 3-cycle glitch of seg=8'h00 between digits -> no capture from the glitch; the frame still decodes correctly.
- Anode faults:
  - an=4'b1100 held 6 cycles -> single an_err pulse, no frame_valid.
  - an=4'b1111 held -> no an_err.
- Stale: stop scanning for TIMEOUT_CYCLES=100 -> stale=1 at cycle 100; resuming the scan -> stale=0 on the first capture.
- Scan order (SCAN_ORDER_CHECK_EN defined): capture order 0,1,3 -> order_err pulse at digit 3, mask=4'b1000. Continuing 0,1,2 -> frame_valid.
